var_loader: RTL and testbench
=============================

VAR_LOADER -- requirements
Module: var_loader

Interface
REQ-001 SHALL have parameter ADRBW, default 20, meaning SRAM address width.
REQ-002 SHALL have parameter WRDBW, default 16, meaning SRAM word width.
REQ-003 SHALL have parameter VARBW, default 16, meaning variable-size (word count) width.
REQ-004 SHALL have port i_clk  input  1  sole clock, all state on rising edge.
REQ-005 SHALL have port i_rst_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have port i_start  input  1  load request, sampled only in IDLE.
REQ-007 SHALL have port i_base_addr  input  ADRBW  SRAM address of least-significant word.
REQ-008 SHALL have port i_nwords  input  VARBW  number of words to stream in.
REQ-009 SHALL have port i_data  input  WRDBW  incoming word, LS word first.
REQ-010 SHALL have port i_data_valid  input  1  i_data valid this cycle.
REQ-011 SHALL have port o_data_ready  output  1  block accepts i_data this cycle.
REQ-012 SHALL have port o_wen  output  1  SRAM write enable (SRAM writes on next rising edge).
REQ-013 SHALL have port o_addr  output  ADRBW  SRAM write address.
REQ-014 SHALL have port o_wdata  output  WRDBW  SRAM write data.
REQ-015 SHALL have port o_varsize  output  VARBW  trimmed size of loaded variable.
REQ-016 SHALL have port o_busy  output  1  high while not IDLE.
REQ-017 SHALL have port o_done  output  1  one-cycle completion pulse.

Function
REQ-018 SHALL implement states IDLE, LOAD, FIN.
- IDLE: i_start=1 -> latch i_base_addr, i_nwords; clear word counter and last-nonzero tracker; go LOAD (i_nwords!=0) or FIN (i_nwords==0).
- LOAD: stay until the i_nwords-th word is accepted, then go FIN.
- FIN: one cycle, o_done=1, go IDLE.
REQ-019 SHALL drive o_data_ready=1 exactly in LOAD, combinationally from state.
REQ-020 SHALL accept a word when i_data_valid & o_data_ready; stalls (valid=0) hold all state.
REQ-021 SHALL, on accept, drive o_wen=1, o_addr=base+count (mod 2^ADRBW), o_wdata=i_data in the same cycle; otherwise o_wen=0, o_addr=0, o_wdata=0.
REQ-022 SHALL write every accepted word, including zero words; no skipping.
REQ-023 SHALL record count as last-nonzero index whenever an accepted word is nonzero.
REQ-024 SHALL, on entering FIN, update o_varsize = last-nonzero index + 1; 1 if all accepted words zero; 0 if i_nwords==0.
REQ-025 SHALL hold o_varsize stable from FIN until the next accepted i_start.
REQ-026 SHALL ignore i_start while o_busy=1; i_data_valid outside LOAD SHALL be ignored.
REQ-027 SHALL assert o_done in the cycle after the last write (latency: last accept edge -> o_done high next cycle), for exactly one cycle.
REQ-028 SHALL assert o_busy in LOAD and FIN, deassert in IDLE.
REQ-029 SHALL permit i_start in the cycle o_done falls (first IDLE cycle) with no dead cycle beyond FIN.
REQ-030 SHALL wrap o_addr modulo 2^ADRBW when base+count overflows.
REQ-031 SHALL use a counter of VARBW bits; i_nwords=2^VARBW-1 SHALL complete without overflow.

Reset
REQ-032 SHALL, on i_rst_n=0 at any time (including mid-LOAD), asynchronously enter IDLE and clear counter, tracker, latched inputs, and outputs: o_data_ready=0, o_wen=0, o_addr=0, o_wdata=0, o_varsize=0, o_busy=0, o_done=0.
REQ-033 SHALL leave SRAM contents written before reset unchanged (no rollback) and produce no o_done for the aborted load.

Verification
REQ-034 SHALL verify: base=0, nwords=2, data 16'hd20c,16'h83d3 back-to-back -> writes addr0=d20c, addr1=83d3 on consecutive cycles, o_done 1 cycle after second write, o_varsize=2.
REQ-035 SHALL verify: base=10, nwords=4, data 6B75,B0AC,0000,0000 with valid low 3 cycles between words -> 4 writes at 10..13 only on valid cycles, o_varsize=2.
REQ-036 SHALL verify: nwords=3 all-zero data -> 3 writes of 0, o_varsize=1; nwords=0 -> no o_wen, o_done on 2nd cycle after start, o_varsize=0.
REQ-037 SHALL verify: base=20'hFFFFF, nwords=2 -> writes at FFFFF then 00000.
REQ-038 SHALL verify: i_start pulsed during LOAD is ignored; i_rst_n low after 1 of 3 words -> all outputs 0 immediately, no o_done, next load after reset works normally.
REQ-039 SHALL verify: back-to-back loads with i_start in first IDLE cycle after o_done -> second load's o_varsize replaces first only at its own FIN.

Source files
------------

// File: rtl/var_loader.sv
// Streams i_nwords words from a valid-qualified input into consecutive SRAM addresses,
// then reports the variable size trimmed of its most-significant zero words.
module var_loader #(
   parameter int ADRBW = 20,
   parameter int WRDBW = 16,
   parameter int VARBW = 16
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_start,
   input  logic [ADRBW-1:0] i_base_addr,
   input  logic [VARBW-1:0] i_nwords,
   input  logic [WRDBW-1:0] i_data,
   input  logic             i_data_valid,
   output logic             o_data_ready,
   output logic             o_wen,
   output logic [ADRBW-1:0] o_addr,
   output logic [WRDBW-1:0] o_wdata,
   output logic [VARBW-1:0] o_varsize,
   output logic             o_busy,
   output logic             o_done
);

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_FIN} state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [ADRBW-1:0] r_base;
   logic [VARBW-1:0] r_nwords;
   logic [VARBW-1:0] r_count;
   logic [VARBW-1:0] r_last_nz;
   logic             r_any_nz;
   logic [VARBW-1:0] r_varsize;

   logic             w_accept;
   logic             w_last;
   logic             w_nz;
   logic             w_start;

   assign w_accept = i_data_valid & (r_state == S_LOAD);
   assign w_last   = (r_count == (r_nwords - VARBW'(1)));
   assign w_nz     = (i_data != '0);
   assign w_start  = i_start & (r_state == S_IDLE);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt  = r_state;
      o_data_ready = 1'b0;
      o_busy       = 1'b0;
      o_done       = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (i_start) begin
               w_state_nxt = (i_nwords == '0) ? S_FIN : S_LOAD;
            end
         end
         S_LOAD: begin
            o_data_ready = 1'b1;
            o_busy       = 1'b1;
            if (w_accept && w_last) begin
               w_state_nxt = S_FIN;
            end
         end
         S_FIN: begin
            o_busy      = 1'b1;
            o_done      = 1'b1;
            w_state_nxt = S_IDLE;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // Write port is purely combinational so the SRAM sees the word in its accept cycle.
   assign o_wen     = w_accept;
   assign o_addr    = w_accept ? (r_base + ADRBW'(r_count)) : '0;
   assign o_wdata   = w_accept ? i_data : '0;
   assign o_varsize = r_varsize;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_base    <= '0;
         r_nwords  <= '0;
         r_count   <= '0;
         r_last_nz <= '0;
         r_any_nz  <= 1'b0;
         r_varsize <= '0;
      end else if (w_start) begin
         r_base    <= i_base_addr;
         r_nwords  <= i_nwords;
         r_count   <= '0;
         r_last_nz <= '0;
         r_any_nz  <= 1'b0;
         if (i_nwords == '0) begin
            r_varsize <= '0;
         end
      end else if (w_accept) begin
         r_count <= r_count + VARBW'(1);
         if (w_nz) begin
            r_last_nz <= r_count;
            r_any_nz  <= 1'b1;
         end
         // Size is resolved on the final accept so it lands as FIN is entered.
         if (w_last) begin
            if (w_nz) begin
               r_varsize <= r_count + VARBW'(1);
            end else if (r_any_nz) begin
               r_varsize <= r_last_nz + VARBW'(1);
            end else begin
               r_varsize <= VARBW'(1);
            end
         end
      end
   end

endmodule

// File: tb/tb_var_loader.sv
// Randomized bench for var_loader: a per-load model predicts every write and the trimmed size.
module tb_var_loader;

   logic        clk;
   logic        i_rst_n;
   logic        i_start;
   logic [19:0] i_base_addr;
   logic [15:0] i_nwords;
   logic [15:0] i_data;
   logic        i_data_valid;
   logic        o_data_ready;
   logic        o_wen;
   logic [19:0] o_addr;
   logic [15:0] o_wdata;
   logic [15:0] o_varsize;
   logic        o_busy;
   logic        o_done;

   int          n_cmp = 0;
   int          n_bad = 0;
   logic [15:0] exp_vs = '0;
   logic [15:0] words[$];

   var_loader #(.ADRBW(20), .WRDBW(16), .VARBW(16)) dut (
      .i_clk        (clk),
      .i_rst_n      (i_rst_n),
      .i_start      (i_start),
      .i_base_addr  (i_base_addr),
      .i_nwords     (i_nwords),
      .i_data       (i_data),
      .i_data_valid (i_data_valid),
      .o_data_ready (o_data_ready),
      .o_wen        (o_wen),
      .o_addr       (o_addr),
      .o_wdata      (o_wdata),
      .o_varsize    (o_varsize),
      .o_busy       (o_busy),
      .o_done       (o_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Trimmed size: index of the highest nonzero word plus one, at least 1 for a non-empty load.
   function automatic logic [15:0] model_vs(input int n);
      int top;
      top = 0;
      for (int k = 0; k < n; k++) begin
         if (words[k] != 16'h0) top = k + 1;
      end
      if (n == 0) return 16'h0;
      if (top == 0) return 16'h1;
      return 16'(top);
   endfunction

   task automatic chk_quiet(input string tag);
      chk({tag, "_rdy"},  32'(o_data_ready), 32'h0);
      chk({tag, "_wen"},  32'(o_wen),        32'h0);
      chk({tag, "_addr"}, 32'(o_addr),       32'h0);
      chk({tag, "_wd"},   32'(o_wdata),      32'h0);
   endtask

   task automatic idle(input int cycles);
      for (int k = 0; k < cycles; k++) begin
         i_start      = 1'b0;
         i_data_valid = 1'($urandom_range(0, 1));
         i_data       = 16'($urandom);
         #1;
         chk("idle_busy", 32'(o_busy), 32'h0);
         chk("idle_done", 32'(o_done), 32'h0);
         chk("idle_vs",   32'(o_varsize), 32'(exp_vs));
         chk_quiet("idle");
         @(negedge clk);
      end
      i_data_valid = 1'b0;
   endtask

   // Entered at a negedge with the DUT in IDLE; returns at the negedge of the first IDLE cycle.
   task automatic run_load(input logic [19:0] base, input int n, input int gap);
      logic [15:0] new_vs;
      logic [19:0] a;
      int          g;
      new_vs       = model_vs(n);
      i_start      = 1'b1;
      i_base_addr  = base;
      i_nwords     = 16'(n);
      i_data_valid = 1'($urandom_range(0, 1));
      i_data       = 16'($urandom);
      #1;
      chk("start_busy", 32'(o_busy), 32'h0);
      chk("start_vs",   32'(o_varsize), 32'(exp_vs));
      chk_quiet("start");
      @(negedge clk);
      i_start = 1'b0;
      for (int idx = 0; idx < n; idx++) begin
         g = (idx == 0) ? 0 : ((gap < 0) ? int'($urandom_range(0, 2)) : gap);
         for (int s = 0; s < g; s++) begin
            i_data_valid = 1'b0;
            i_data       = 16'($urandom);
            i_start      = ($urandom_range(0, 3) == 0);
            #1;
            chk("stall_rdy",  32'(o_data_ready), 32'h1);
            chk("stall_wen",  32'(o_wen),   32'h0);
            chk("stall_addr", 32'(o_addr),  32'h0);
            chk("stall_wd",   32'(o_wdata), 32'h0);
            chk("stall_done", 32'(o_done),  32'h0);
            chk("stall_vs",   32'(o_varsize), 32'(exp_vs));
            @(negedge clk);
         end
         a            = base + 20'(idx);
         i_data_valid = 1'b1;
         i_data       = words[idx];
         i_start      = ($urandom_range(0, 3) == 0);
         #1;
         chk("ld_rdy",  32'(o_data_ready), 32'h1);
         chk("ld_busy", 32'(o_busy),  32'h1);
         chk("ld_wen",  32'(o_wen),   32'h1);
         chk("ld_addr", 32'(o_addr),  32'(a));
         chk("ld_wd",   32'(o_wdata), 32'(words[idx]));
         chk("ld_done", 32'(o_done),  32'h0);
         chk("ld_vs",   32'(o_varsize), 32'(exp_vs));
         @(negedge clk);
      end
      i_data_valid = 1'($urandom_range(0, 1));
      i_data       = 16'($urandom);
      i_start      = 1'($urandom_range(0, 1));
      #1;
      chk("fin_done", 32'(o_done), 32'h1);
      chk("fin_busy", 32'(o_busy), 32'h1);
      chk("fin_vs",   32'(o_varsize), 32'(new_vs));
      chk_quiet("fin");
      exp_vs = new_vs;
      @(negedge clk);
      i_start      = 1'b0;
      i_data_valid = 1'b0;
   endtask

   initial begin
      i_rst_n      = 1'b0;
      i_start      = 1'b0;
      i_base_addr  = '0;
      i_nwords     = '0;
      i_data       = '0;
      i_data_valid = 1'b0;
      #3;
      chk("rst_busy", 32'(o_busy), 32'h0);
      chk("rst_done", 32'(o_done), 32'h0);
      chk("rst_vs",   32'(o_varsize), 32'h0);
      chk_quiet("rst");
      @(negedge clk);
      @(negedge clk);
      i_rst_n = 1'b1;

      words = '{16'hd20c, 16'h83d3};
      run_load(20'h0, 2, 0);
      idle(1);
      words = '{16'h6B75, 16'hB0AC, 16'h0000, 16'h0000};
      run_load(20'd10, 4, 3);
      words = '{16'h0, 16'h0, 16'h0};
      run_load(20'd40, 3, 0);
      words.delete();
      run_load(20'd55, 0, 0);
      words = '{16'h1234, 16'h0001};
      run_load(20'hFFFFF, 2, 1);
      idle(2);

      // Abort after one of three words; the second word is on the bus when reset hits.
      words        = '{16'hAAAA, 16'hBBBB, 16'hCCCC};
      i_start      = 1'b1;
      i_base_addr  = 20'd100;
      i_nwords     = 16'd3;
      @(negedge clk);
      i_start      = 1'b0;
      i_data_valid = 1'b1;
      i_data       = words[0];
      #1;
      chk("ab_wen", 32'(o_wen), 32'h1);
      @(negedge clk);
      i_data = words[1];
      #1;
      chk("ab_wen2", 32'(o_wen), 32'h1);
      i_rst_n = 1'b0;
      #1;
      chk("ab_busy", 32'(o_busy), 32'h0);
      chk("ab_done", 32'(o_done), 32'h0);
      chk("ab_vs",   32'(o_varsize), 32'h0);
      chk_quiet("ab");
      exp_vs = '0;
      @(negedge clk);
      i_rst_n      = 1'b1;
      i_data_valid = 1'b0;
      idle(3);
      words = '{16'h0, 16'h5A5A, 16'h0};
      run_load(20'd200, 3, -1);

      for (int r = 0; r < 30; r++) begin
         int          n;
         logic [19:0] b;
         n = int'($urandom_range(0, 12));
         words.delete();
         for (int k = 0; k < n; k++) begin
            words.push_back(($urandom_range(0, 1) == 0) ? 16'h0 : 16'($urandom));
         end
         b = ($urandom_range(0, 3) == 0) ? (20'hFFFF8 + 20'($urandom_range(0, 7)))
                                         : 20'($urandom);
         run_load(b, n, -1);
         if ($urandom_range(0, 1) == 1) idle(int'($urandom_range(1, 2)));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
